// File: rtl/display_scan_ctrl_if.sv
// Host-side bus of the 8-digit scan controller: shadow writes, commit request,
// scan enable, and the digit index / segment pattern sent to the line decoder.
interface display_scan_ctrl_if;
    logic       scan_en;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       commit;
    logic [2:0] counter;
    logic [7:0] seg;
    logic       frame_tick;
    logic       commit_pending;

    modport master (
        output scan_en, wr_en, wr_addr, wr_data, commit,
        input  counter, seg, frame_tick, commit_pending
    );

    modport slave (
        input  scan_en, wr_en, wr_addr, wr_data, commit,
        output counter, seg, frame_tick, commit_pending
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 8-digit display scanner with a double-buffered segment store.
// Shadow writes reach the displayed bank only at a frame boundary (or while paused).
module display_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    display_scan_ctrl_if.slave bus
);
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] LAST  = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK = PW'(BLANK_CYC);

    typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} commit_state_t;

    commit_state_t state;
    logic [PW-1:0] presc, presc_n;
    logic [2:0]    cnt, cnt_n;
    logic [7:0]    seg_q, seg_n;
    logic          tick_q;
    logic          boundary;
    logic          copy;
    logic [7:0]    shadow [8];
    logic [7:0]    active [8];

    // Next scan position, frame boundary and bank copy decision.
    // seg is looked up from the post-edge position and post-edge active bank
    // so a new digit never appears with a stale pattern.
    always_comb begin
        presc_n  = '0;
        cnt_n    = cnt;
        boundary = 1'b0;
        if (bus.scan_en) begin
            if (presc == LAST) begin
                cnt_n    = cnt + 3'd1;
                boundary = (cnt == 3'd7);
            end else begin
                presc_n = presc + 1'b1;
            end
        end

        copy = 1'b0;
        if (state == PENDING) begin
            copy = boundary || !bus.scan_en;
        end else begin
            copy = bus.commit && !bus.scan_en;
        end

        seg_n = '0;
        if (bus.scan_en && (presc_n >= BLANK)) begin
            seg_n = copy ? shadow[cnt_n] : active[cnt_n];
        end
    end

    // Scan position, registered outputs, both banks and the commit FSM.
    // The copy reads shadow before this edge's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            presc  <= '0;
            cnt    <= '0;
            seg_q  <= '0;
            tick_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            presc  <= presc_n;
            cnt    <= cnt_n;
            seg_q  <= seg_n;
            tick_q <= boundary;

            if (copy) begin
                for (int i = 0; i < 8; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (bus.wr_en) begin
                shadow[bus.wr_addr] <= bus.wr_data;
            end

            case (state)
                IDLE:    if (bus.commit && bus.scan_en) state <= PENDING;
                PENDING: if (copy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.counter        = cnt;
    assign bus.seg            = seg_q;
    assign bus.frame_tick     = tick_q;
    assign bus.commit_pending = (state == PENDING);
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random traffic,
// checked every cycle against a frame-position reference model.
module tb_display_scan_ctrl;
    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = 8 * CLK_DIV;

    logic clk = 1'b0;
    logic rst_n;
    display_scan_ctrl_if bus();

    display_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the frame plus two plain banks.
    int       m_pos;
    bit       m_pending;
    bit       m_tick;
    bit [7:0] m_seg;
    bit [7:0] m_shadow [8];
    bit [7:0] m_active [8];

    task automatic modelReset();
        m_pos = 0;
        m_pending = 0;
        m_tick = 0;
        m_seg = 0;
        for (int i = 0; i < 8; i++) begin
            m_shadow[i] = 0;
            m_active[i] = 0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".counter"}, 32'(bus.counter), 32'(m_pos / CLK_DIV));
        checkOutput({tag, ".seg"}, 32'(bus.seg), 32'(m_seg));
        checkOutput({tag, ".frame_tick"}, 32'(bus.frame_tick), 32'(m_tick));
        checkOutput({tag, ".pending"}, 32'(bus.commit_pending), 32'(m_pending));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic applyStimulus(input bit se, input bit we, input bit [2:0] a,
                                 input bit [7:0] d, input bit cm);
        bit do_copy;
        bit bnd;
        bus.scan_en = se;
        bus.wr_en   = we;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.commit  = cm;
        @(posedge clk);
        bnd = se && (m_pos == FRAME - 1);
        do_copy = m_pending ? (bnd || !se) : (cm && !se);
        if (do_copy) begin
            for (int i = 0; i < 8; i++) m_active[i] = m_shadow[i];
            m_pending = 0;
        end else if (cm && se) begin
            m_pending = 1;
        end
        if (we) m_shadow[a] = d;
        if (se) m_pos = (m_pos + 1) % FRAME;
        else    m_pos = (m_pos / CLK_DIV) * CLK_DIV;
        m_tick = bnd;
        m_seg = (se && (m_pos % CLK_DIV) >= BLANK_CYC) ? m_active[m_pos / CLK_DIV] : 8'h00;
        #1;
        checkAll("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0);
    endtask

    task automatic idleUntilDigit(input int digit);
        int budget = 200;
        while ((m_pos / CLK_DIV != digit || m_pos % CLK_DIV != 0) && budget > 0) begin
            applyStimulus(1, 0, 0, 0, 0);
            budget--;
        end
        if (budget == 0) checkOutput("wait_digit_timeout", 1, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.scan_en = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.commit = 0;
        modelReset();
        #3;
        checkAll("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Blank full frame with all entries zero; frame_tick at the wrap.
        idle(FRAME + 4);

        // Mid-frame commit of digit 3, shown only after the boundary.
        idleUntilDigit(1);
        applyStimulus(1, 1, 3'd3, 8'hA5, 0);
        applyStimulus(1, 0, 0, 0, 1);
        idle(2 * FRAME);

        // Write landing on the very edge that performs a pending copy.
        applyStimulus(1, 0, 0, 0, 1);
        begin
            int budget = 200;
            while (m_pos != FRAME - 1 && budget > 0) begin
                applyStimulus(1, 0, 0, 0, 0);
                budget--;
            end
            if (budget == 0) checkOutput("wait_boundary_timeout", 1, 0);
        end
        applyStimulus(1, 1, 3'd5, 8'h3C, 0);
        idle(FRAME);
        applyStimulus(1, 0, 0, 0, 1);
        idle(2 * FRAME);

        // Paused commit copies immediately; resumes from the held digit.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 3'd0, 8'hFF, 0);
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0);
        idle(2 * FRAME);

        // Two commit pulses in one frame; one copy at the boundary.
        applyStimulus(1, 1, 3'd2, 8'h81, 1);
        idle(3);
        applyStimulus(1, 1, 3'd2, 8'h42, 1);
        idle(2 * FRAME);

        // Async reset at digit 6 with a commit pending.
        applyStimulus(1, 1, 3'd6, 8'h77, 0);
        applyStimulus(1, 0, 0, 0, 1);
        idleUntilDigit(6);
        applyStimulus(1, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(FRAME + 8);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
                          3'($urandom_range(0, 7)), 8'($urandom),
                          ($urandom_range(0, 19) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Upstream driver for the 8-digit common-line decoder: produces the 3-bit `counter` digit index that the decoder turns into COM1..COM8, and the matching segment pattern for the active digit.
- Holds a double-buffered 8-entry segment store. Host writes go to a shadow bank and are committed to the displayed bank only at a frame boundary, so a partly updated frame is never shown.
- Blanks segments at the start of each digit slot to suppress ghosting.

Parameters:
- CLK_DIV, 50000, clock cycles per digit slot; legal range is 2 or more.
- BLANK_CYC, 16, cycles at the start of each slot during which seg is forced to 0; must be less than CLK_DIV.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- scan_en  in  1  1 = scanning runs; 0 = scan paused and segments blanked.
- wr_en  in  1  write strobe for the shadow bank.
- wr_addr  in  3  shadow entry index, 0..7.
- wr_data  in  8  segment pattern (bit 0 = seg a … bit 7 = dp).
- commit  in  1  single-cycle pulse requesting shadow-to-active copy.
- counter  out  3  current digit index, feeds the 3-to-8 decoder.
- seg  out  8  segment pattern for the digit selected by counter.
- frame_tick  out  1  one-cycle pulse when counter wraps from 7 to 0.
- commit_pending  out  1  a commit is waiting for the next frame boundary.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - prescaler=0, counter=0, seg=0, frame_tick=0, commit_pending=0.
  - All active and shadow entries are 0.
  - A reset in mid-frame discards scan position, any pending commit and shadow contents.
- All outputs are registered.
- Prescaler, with scan_en=1:
  - Counts 0..CLK_DIV-1.
  - When the prescaler is at CLK_DIV-1, the next edge sets it to 0 and increments counter mod 8.
  - The 7→0 transition is a frame boundary. frame_tick is 1 for exactly the first cycle in which counter=0.
- Pause, with scan_en=0:
  - Prescaler is cleared to 0 and counter holds.
  - seg=0 and frame_tick=0.
  - On re-enable, the slot restarts from prescaler 0 with blanking.
- Segment output:
  - seg is registered and valid in the same cycle as the counter/prescaler state it corresponds to.
  - seg = 0 when scan_en=0 or prescaler < BLANK_CYC.
  - Otherwise seg = active[counter].
  - counter and seg change on the same edge, so no cycle shows a new digit with the old pattern.
- Shadow write:
  - With wr_en=1, shadow[wr_addr] <= wr_data on the edge.
  - The active bank is never written directly.
  - Back-to-back writes are allowed every cycle.
- Commit FSM, states IDLE and PENDING:
  - IDLE + commit with scan_en=1 → PENDING; commit_pending=1 from the next cycle.
  - IDLE + commit with scan_en=0 → active <= shadow on that edge; stays in IDLE.
  - PENDING + frame boundary edge → active <= all 8 shadow entries → IDLE; commit_pending=0.
  - PENDING + scan_en falling to 0 → copy on the next edge → IDLE.
  - commit while in PENDING is ignored; no second copy occurs.
- Simultaneous events:
  - A write on the same edge as the copy is not included in that copy: the copy uses shadow contents before the edge. The write lands in shadow and needs a further commit.
  - A commit pulse on the same edge as a frame boundary, from IDLE, enters PENDING and copies at the following boundary.
- Write to the entry currently displayed: no effect on seg until committed.
- wr_addr is always in range because it is 3 bits; there is no error path.

Test Plan:
- CLK_DIV=8, BLANK_CYC=2. Reset, then scan_en=1 → counter steps 0,1,…,7 every 8 cycles. frame_tick pulses once at cycle 64 with counter=0. seg=0 throughout because all entries are 0.
- Write shadow[3]=0xA5, commit mid-frame (counter=1) → commit_pending=1 and seg stays 0 during digit 3 of the current frame. After the boundary, digit 3 shows seg=0 in slot cycles 0–1 and 0xA5 in cycles 2–7. commit_pending=0.
- Write shadow[5]=0x3C on the exact boundary edge of a pending copy → copy omits it (digit 5 stays 0). A second commit shows 0x3C in the following frame.
- scan_en=0, write shadow[0]=0xFF, commit → active[0]=0xFF next cycle with no pending state. seg=0 while paused. After re-enable at counter=0, seg=0xFF from slot cycle 2.
- Assert rst_n=0 asynchronously while counter=6 with a commit pending → counter, seg, frame_tick and commit_pending go to 0 immediately without a clock edge. After release, the display stays blank even after the next frame boundary.
- Two commit pulses in one frame → exactly one copy, and commit_pending drops once at the boundary.
